// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
// Multi-cycle conditional-branch resolver. Accepts one branch at a time over a
// valid/ready handshake, registers the operands, computes the six RISC-V branch
// condition flags, selects one by funct3 and returns taken/target/next_pc over
// a second valid/ready handshake. Also keeps saturating branch/taken counters.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   funct3, rs1, rs2, pc, imm  branch request fields
//   resp_valid / resp_ready    response handshake
//   taken, target, next_pc     resolution results (hold until next resolution)
//   illegal, misaligned        funct3 010/011; taken with target[1:0] != 0
//   branch_count, taken_count  saturating performance counters
module branch_resolve_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic [XLEN-1:0]  next_pc,
  output logic             illegal,
  output logic             misaligned,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    SEL  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [2:0]      f3_q;
  logic [XLEN-1:0] rs1_q, rs2_q, pc_q, imm_q, pc4_q;
  // flags_q: {BGEU, BLTU, BGE, BLT, BNE, BEQ}
  logic [5:0]      flags_q;
  logic            sel_taken, sel_illegal;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = CMP;
      end
      CMP:  state_nxt = SEL;
      SEL:  state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Condition select by funct3 from the registered flags
  always_comb begin
    sel_taken   = 1'b0;
    sel_illegal = 1'b0;
    unique case (f3_q)
      3'b000: sel_taken = flags_q[0];
      3'b001: sel_taken = flags_q[1];
      3'b100: sel_taken = flags_q[2];
      3'b101: sel_taken = flags_q[3];
      3'b110: sel_taken = flags_q[4];
      3'b111: sel_taken = flags_q[5];
      default: sel_illegal = 1'b1;
    endcase
  end

  // Datapath registers; results only change in SEL, so they hold through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      pc4_q        <= '0;
      flags_q      <= '0;
      taken        <= 1'b0;
      target       <= '0;
      next_pc      <= '0;
      illegal      <= 1'b0;
      misaligned   <= 1'b0;
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q  <= funct3;
            rs1_q <= rs1;
            rs2_q <= rs2;
            pc_q  <= pc;
            imm_q <= imm;
          end
        end
        CMP: begin
          flags_q[0] <= (rs1_q == rs2_q);
          flags_q[1] <= (rs1_q != rs2_q);
          flags_q[2] <= ($signed(rs1_q) <  $signed(rs2_q));
          flags_q[3] <= ($signed(rs1_q) >= $signed(rs2_q));
          flags_q[4] <= (rs1_q <  rs2_q);
          flags_q[5] <= (rs1_q >= rs2_q);
          target     <= pc_q + imm_q;
          pc4_q      <= pc_q + XLEN'(4);
        end
        SEL: begin
          taken      <= sel_taken;
          illegal    <= sel_illegal;
          next_pc    <= sel_taken ? target : pc4_q;
          misaligned <= sel_taken & (target[1:0] != 2'b00);
          if (!sel_illegal && branch_count != '1)
            branch_count <= branch_count + CNT_W'(1);
          if (sel_taken && taken_count != '1)
            taken_count <= taken_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl (CNT_W=4 so saturation is reachable).
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, pc, imm;
  logic        resp_valid, resp_ready;
  logic        taken, illegal, misaligned;
  logic [31:0] target, next_pc;
  logic [3:0]  branch_count, taken_count;

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic        e_taken, e_ill, e_mis;
  logic [31:0] e_target, e_next;
  int          m_bc, m_tc;

  branch_resolve_ctrl #(.XLEN(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .taken(taken), .target(target), .next_pc(next_pc),
    .illegal(illegal), .misaligned(misaligned),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Branch semantics from the ISA definition
  task automatic model(input logic [2:0] f3, input logic [31:0] a, b, p, i);
    e_ill = (f3 == 3'b010) || (f3 == 3'b011);
    case (f3)
      3'b000:  e_taken = (a == b);
      3'b001:  e_taken = (a != b);
      3'b100:  e_taken = ($signed(a) <  $signed(b));
      3'b101:  e_taken = ($signed(a) >= $signed(b));
      3'b110:  e_taken = (a <  b);
      3'b111:  e_taken = (a >= b);
      default: e_taken = 1'b0;
    endcase
    e_target = p + i;
    e_next   = e_taken ? e_target : p + 32'd4;
    e_mis    = e_taken && (e_target[1:0] != 2'b00);
    if (!e_ill && m_bc < 15) m_bc++;
    if (e_taken && m_tc < 15) m_tc++;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_resp_valid"}, resp_valid, 1);
    chk({ph, "_taken"}, taken, e_taken);
    chk({ph, "_illegal"}, illegal, e_ill);
    chk({ph, "_misaligned"}, misaligned, e_mis);
    chk({ph, "_target"}, target, e_target);
    chk({ph, "_next_pc"}, next_pc, e_next);
    chk({ph, "_branch_count"}, branch_count, m_bc);
    chk({ph, "_taken_count"}, taken_count, m_tc);
  endtask

  // Called at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [2:0] f3, input logic [31:0] a, b, p, i);
    int n = 0;
    funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = i;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", (n < 20), 1);
    @(posedge clk);
    model(f3, a, b, p, i);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic recv(input int stall);
    int lat = 0;
    resp_ready = (stall == 0);
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 2);
    check_outputs("resp");
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check_outputs("stall");
      chk("stall_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("drop_resp_valid", resp_valid, 0);
    chk("idle_req_ready", req_ready, 1);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    m_bc = 0; m_tc = 0;
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    funct3 = '0; rs1 = '0; rs2 = '0; pc = '0; imm = '0;

    // Reset state
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_taken", taken, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_misaligned", misaligned, 0);
    chk("rst_target", target, 0);
    chk("rst_next_pc", next_pc, 0);
    chk("rst_branch_count", branch_count, 0);
    chk("rst_taken_count", taken_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // BEQ directed
    send(3'b000, 32'h10, 32'h10, 32'h100, 32'h20);
    recv(0);
    chk("beq_target", target, 32'h120);
    chk("beq_next_pc", next_pc, 32'h120);
    chk("beq_branch_count", branch_count, 1);
    chk("beq_taken_count", taken_count, 1);

    // Signed vs unsigned
    send(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40); recv(0);
    chk("blt_taken", taken, 1);
    send(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40); recv(0);
    chk("bltu_taken", taken, 0);
    chk("bltu_next_pc", next_pc, 32'h204);
    send(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40); recv(0);
    chk("bgeu_taken", taken, 1);

    // Illegal, wrap, misaligned
    send(3'b010, 32'h5, 32'h5, 32'h300, 32'h8); recv(0);
    chk("illegal_flag", illegal, 1);
    chk("illegal_next_pc", next_pc, 32'h304);
    send(3'b000, 32'h5, 32'h5, 32'hFFFF_FFF0, 32'h20); recv(0);
    chk("wrap_target", target, 32'h10);
    send(3'b000, 32'h5, 32'h5, 32'h100, 32'h2); recv(0);
    chk("misaligned_flag", misaligned, 1);

    // Back-pressure with a second request held pending
    send(3'b001, 32'h1, 32'h2, 32'h400, 32'h10);
    funct3 = 3'b101; rs1 = 32'h8000_0000; rs2 = 32'h1; pc = 32'h500; imm = 32'hFFFF_FFF0;
    req_valid = 1'b1;
    recv(5);
    send(3'b101, 32'h8000_0000, 32'h1, 32'h500, 32'hFFFF_FFF0);
    recv(0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      send(rf3, ra, rb, $urandom, $urandom);
      recv($urandom_range(0, 2));
    end

    // Reset while in CMP
    send(3'b000, 32'h1, 32'h1, 32'h600, 32'h4);
    rst_n = 1'b0;
    m_bc = 0; m_tc = 0;
    #1;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_branch_count", branch_count, 0);
    chk("midrst_taken_count", taken_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_no_resp", resp_valid, 0);
    end

    // Saturation at 4-bit width
    for (int t = 0; t < 17; t++) begin
      send(3'b000, 32'h7, 32'h7, 32'h700, 32'h8);
      recv(0);
    end
    chk("sat_branch_count", branch_count, 15);
    chk("sat_taken_count", taken_count, 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Multi-cycle branch resolution controller for the RISC-V datapath. It accepts one conditional-branch request at a time from the decode/execute stage over a valid/ready handshake. It registers the operands, computes the six branch condition flags (BEQ, BNE, BLT, BGE, BLTU, BGEU), selects one flag by funct3, and returns taken, target and next PC to the PC-update logic over a second valid/ready handshake. It also maintains saturating branch and taken counters for performance monitoring.

Parameters:
XLEN, 32, operand/PC width in bits
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request
funct3  in  3  branch type (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU)
rs1  in  XLEN  first operand
rs2  in  XLEN  second operand
pc  in  XLEN  PC of branch instruction
imm  in  XLEN  sign-extended B-immediate
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
taken  out  1  branch condition true
target  out  XLEN  pc + imm
next_pc  out  XLEN  target if taken, else pc + 4
illegal  out  1  funct3 is 010 or 011
misaligned  out  1  taken and target[1:0] != 00
branch_count  out  CNT_W  resolved-branch count, saturating
taken_count  out  CNT_W  taken-branch count, saturating

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; resp_valid=0; taken=0; illegal=0; misaligned=0; target=0; next_pc=0; both counters 0. Internal operand and flag registers are cleared.
- Reset asserted mid-operation discards the in-flight request. No response is produced for it.
- FSM states: IDLE, CMP, SEL, RESP.
- IDLE: req_ready=1. When req_valid && req_ready at an edge, latch funct3, rs1, rs2, pc and imm, then go to CMP.
- CMP (1 cycle, req_ready=0): register the flags.
  - BEQ = (rs1==rs2); BNE = !BEQ.
  - BLT = signed rs1<rs2; BGE = !BLT.
  - BLTU = unsigned rs1<rs2; BGEU = !BLTU.
  - Register target = pc+imm and pc+4, both modulo 2^XLEN (wrap, no overflow flag).
  - Go to SEL.
- SEL (1 cycle, req_ready=0): select the flag by funct3 into taken.
  - funct3 010/011: taken=0, illegal=1.
  - next_pc = taken ? target : pc+4.
  - misaligned = taken & (target[1:0]!=0).
  - branch_count increments unless illegal; taken_count increments if taken. Both saturate at all-ones.
  - Go to RESP.
- RESP: resp_valid=1. All outputs stay stable until resp_valid && resp_ready at an edge, then return to IDLE and drop resp_valid on that edge.
- Latency: request accepted at edge N gives resp_valid=1 from edge N+2. With resp_ready held high, the next request is accepted at edge N+4.
- Simultaneous events: req_valid is ignored outside IDLE (req_ready=0). A request that appears while in RESP waits; it is not dropped.
- Illegal funct3 still produces a response, with next_pc=pc+4.
- Outputs other than resp_valid are don't-care-stable between responses. They hold their last value.

Test Plan:
- Reset then BEQ: rs1=rs2=0x10, pc=0x100, imm=0x20, funct3=000 -> resp_valid at accept+2; taken=1, target=0x120, next_pc=0x120; branch_count=1, taken_count=1.
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=1. funct3=100 -> taken=1. funct3=110 -> taken=0 with next_pc=pc+4. funct3=111 -> taken=1.
- Illegal and wrap: funct3=010 -> illegal=1, taken=0, branch_count unchanged. Separately, pc=0xFFFFFFF0, imm=0x20, BEQ taken -> target=0x00000010. pc=0x100, imm=0x2, taken -> misaligned=1.
- Back-pressure: resp_ready=0 for 5 cycles with req_valid held high -> outputs stable, req_ready=0 throughout; the second request is accepted only after the resp handshake.
- Reset mid-operation: pulse rst_n low while in CMP -> no resp_valid, counters 0, req_ready=1 immediately.
- Saturation: CNT_W=4, 17 taken branches -> branch_count=taken_count=15.
